// File: rtl/alu_cmd_sequencer.sv
// Command sequencer that drives a combinational ALU with registered operands,
// waits SETTLE_CYC cycles, captures the result and holds it until consumed.
module alu_cmd_sequencer #(
  parameter int SETTLE_CYC = 1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       cmd_valid_i,
  output logic       cmd_ready_o,
  input  logic [3:0] cmd_a_i,
  input  logic [3:0] cmd_b_i,
  input  logic [3:0] cmd_sel_i,
  output logic [3:0] alu_a_o,
  output logic [3:0] alu_b_o,
  output logic [3:0] alu_sel_o,
  input  logic       alu_c_i,
  input  logic [3:0] alu_out1_i,
  input  logic [3:0] alu_out2_i,
  output logic       rsp_valid_o,
  input  logic       rsp_ready_i,
  output logic       rsp_c_o,
  output logic [3:0] rsp_out1_o,
  output logic [3:0] rsp_out2_o,
  output logic [3:0] rsp_sel_o,
  output logic       rsp_dz_o,
  output logic [7:0] op_count_o
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  localparam logic [3:0] LastCnt = 4'(SETTLE_CYC - 1);
  localparam logic [3:0] OpDiv   = 4'b0011;

  state_e     state_q, state_d;
  logic [3:0] settleCnt_q, settleCnt_d;
  logic [3:0] aluA_q, aluA_d;
  logic [3:0] aluB_q, aluB_d;
  logic [3:0] aluSel_q, aluSel_d;
  logic       rspC_q, rspC_d;
  logic [3:0] rspOut1_q, rspOut1_d;
  logic [3:0] rspOut2_q, rspOut2_d;
  logic [3:0] rspSel_q, rspSel_d;
  logic       rspDz_q, rspDz_d;
  logic [7:0] opCount_q, opCount_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      settleCnt_q <= '0;
      aluA_q      <= '0;
      aluB_q      <= '0;
      aluSel_q    <= '0;
      rspC_q      <= 1'b0;
      rspOut1_q   <= '0;
      rspOut2_q   <= '0;
      rspSel_q    <= '0;
      rspDz_q     <= 1'b0;
      opCount_q   <= '0;
    end else begin
      state_q     <= state_d;
      settleCnt_q <= settleCnt_d;
      aluA_q      <= aluA_d;
      aluB_q      <= aluB_d;
      aluSel_q    <= aluSel_d;
      rspC_q      <= rspC_d;
      rspOut1_q   <= rspOut1_d;
      rspOut2_q   <= rspOut2_d;
      rspSel_q    <= rspSel_d;
      rspDz_q     <= rspDz_d;
      opCount_q   <= opCount_d;
    end
  end

  // Operands stay frozen from acceptance until the next accepted command.
  always_comb begin
    state_d     = state_q;
    settleCnt_d = settleCnt_q;
    aluA_d      = aluA_q;
    aluB_d      = aluB_q;
    aluSel_d    = aluSel_q;
    rspC_d      = rspC_q;
    rspOut1_d   = rspOut1_q;
    rspOut2_d   = rspOut2_q;
    rspSel_d    = rspSel_q;
    rspDz_d     = rspDz_q;
    opCount_d   = opCount_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          aluA_d      = cmd_a_i;
          aluB_d      = cmd_b_i;
          aluSel_d    = cmd_sel_i;
          settleCnt_d = '0;
          state_d     = EXEC;
        end
      end
      EXEC: begin
        settleCnt_d = settleCnt_q + 4'd1;
        if (settleCnt_q == LastCnt) begin
          rspC_d    = alu_c_i;
          rspOut1_d = alu_out1_i;
          rspOut2_d = alu_out2_i;
          rspSel_d  = aluSel_q;
          rspDz_d   = (aluSel_q == OpDiv) && (aluB_q == 4'b0000);
          state_d   = RESP;
        end
      end
      RESP: begin
        if (rsp_ready_i) begin
          opCount_d = opCount_q + 8'd1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign cmd_ready_o = (state_q == IDLE);
  assign rsp_valid_o = (state_q == RESP);
  assign alu_a_o     = aluA_q;
  assign alu_b_o     = aluB_q;
  assign alu_sel_o   = aluSel_q;
  assign rsp_c_o     = rspC_q;
  assign rsp_out1_o  = rspOut1_q;
  assign rsp_out2_o  = rspOut2_q;
  assign rsp_sel_o   = rspSel_q;
  assign rsp_dz_o    = rspDz_q;
  assign op_count_o  = opCount_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer: one instance with SETTLE_CYC=1 and one
// with SETTLE_CYC=4 share all inputs; each scenario task checks its own outputs.
module tb_alu_cmd_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cmdValid = 1'b0;
  logic [3:0] cmdA = '0, cmdB = '0, cmdSel = '0;
  logic       aluC = 1'b0;
  logic [3:0] aluOut1 = '0, aluOut2 = '0;
  logic       rspReady = 1'b0;

  logic       cmdReady1, rspValid1, rspC1, rspDz1;
  logic [3:0] aluA1, aluB1, aluSel1, rspOut1A, rspOut2A, rspSel1;
  logic [7:0] opCount1;
  logic       cmdReady4, rspValid4, rspC4, rspDz4;
  logic [3:0] aluA4, aluB4, aluSel4, rspOut1B, rspOut2B, rspSel4;
  logic [7:0] opCount4;

  int checkCount = 0;
  int passCount  = 0;

  alu_cmd_sequencer #(.SETTLE_CYC(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .cmd_valid_i(cmdValid), .cmd_ready_o(cmdReady1),
    .cmd_a_i(cmdA), .cmd_b_i(cmdB), .cmd_sel_i(cmdSel),
    .alu_a_o(aluA1), .alu_b_o(aluB1), .alu_sel_o(aluSel1),
    .alu_c_i(aluC), .alu_out1_i(aluOut1), .alu_out2_i(aluOut2),
    .rsp_valid_o(rspValid1), .rsp_ready_i(rspReady), .rsp_c_o(rspC1),
    .rsp_out1_o(rspOut1A), .rsp_out2_o(rspOut2A), .rsp_sel_o(rspSel1),
    .rsp_dz_o(rspDz1), .op_count_o(opCount1)
  );

  alu_cmd_sequencer #(.SETTLE_CYC(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .cmd_valid_i(cmdValid), .cmd_ready_o(cmdReady4),
    .cmd_a_i(cmdA), .cmd_b_i(cmdB), .cmd_sel_i(cmdSel),
    .alu_a_o(aluA4), .alu_b_o(aluB4), .alu_sel_o(aluSel4),
    .alu_c_i(aluC), .alu_out1_i(aluOut1), .alu_out2_i(aluOut2),
    .rsp_valid_o(rspValid4), .rsp_ready_i(rspReady), .rsp_c_o(rspC4),
    .rsp_out1_o(rspOut1B), .rsp_out2_o(rspOut2B), .rsp_sel_o(rspSel4),
    .rsp_dz_o(rspDz4), .op_count_o(opCount4)
  );

  always #5 clk = ~clk;

  // Advance one rising edge; inputs change and outputs are sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [3:0] a, input logic [3:0] b,
                               input logic [3:0] sel, input logic c,
                               input logic [3:0] o1, input logic [3:0] o2);
    cmdValid = v; cmdA = a; cmdB = b; cmdSel = sel;
    aluC = c; aluOut1 = o1; aluOut2 = o2;
  endtask

  task automatic doReset();
    rst = 1'b1; tick(); rst = 1'b0;
  endtask

  // Accept a command on dut1 and advance it to RESP.
  task automatic runOp(input logic [3:0] a, input logic [3:0] b, input logic [3:0] sel,
                       input logic c, input logic [3:0] o1, input logic [3:0] o2);
    applyStimulus(1'b1, a, b, sel, c, o1, o2);
    tick();
    cmdValid = 1'b0;
    tick();
  endtask

  task automatic handshake();
    rspReady = 1'b1; tick(); rspReady = 1'b0;
  endtask

  task automatic test_reset();
    applyStimulus(1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0);
    doReset();
    checkCount++; if (cmdReady1 !== 1'b1) $display("[TB] FAIL reset_cmd_ready: got %b expected 1", cmdReady1); else passCount++;
    checkCount++; if (rspValid1 !== 1'b0) $display("[TB] FAIL reset_rsp_valid: got %b expected 0", rspValid1); else passCount++;
    checkCount++; if ({aluA1, aluB1, aluSel1} !== 12'h000) $display("[TB] FAIL reset_alu: got %h expected 000", {aluA1, aluB1, aluSel1}); else passCount++;
    checkCount++; if ({rspC1, rspOut1A, rspOut2A, rspSel1, rspDz1} !== 15'h0) $display("[TB] FAIL reset_rsp: got %h expected 0", {rspC1, rspOut1A, rspOut2A, rspSel1, rspDz1}); else passCount++;
    checkCount++; if (opCount1 !== 8'd0) $display("[TB] FAIL reset_op_count: got %0d expected 0", opCount1); else passCount++;
    rspReady = 1'b1; tick(); rspReady = 1'b0;
    checkCount++; if (opCount1 !== 8'd0) $display("[TB] FAIL idle_rsp_ready_ignored: got %0d expected 0", opCount1); else passCount++;
  endtask

  task automatic test_basic();
    applyStimulus(1'b1, 4'b1011, 4'b0101, 4'b0000, 1'b1, 4'h0, 4'h0);
    tick();
    cmdValid = 1'b0;
    checkCount++; if ({aluA1, aluB1, aluSel1} !== 12'b1011_0101_0000) $display("[TB] FAIL basic_alu_drive: got %b expected 101101010000", {aluA1, aluB1, aluSel1}); else passCount++;
    checkCount++; if (cmdReady1 !== 1'b0 || rspValid1 !== 1'b0) $display("[TB] FAIL basic_exec_flags: got ready=%b valid=%b expected 0/0", cmdReady1, rspValid1); else passCount++;
    tick();
    checkCount++; if (rspValid1 !== 1'b1) $display("[TB] FAIL basic_rsp_valid: got %b expected 1", rspValid1); else passCount++;
    checkCount++; if (rspC1 !== 1'b1 || rspOut1A !== 4'h0 || rspOut2A !== 4'h0) $display("[TB] FAIL basic_rsp_data: got c=%b o1=%h o2=%h expected 1/0/0", rspC1, rspOut1A, rspOut2A); else passCount++;
    checkCount++; if (rspSel1 !== 4'b0000 || rspDz1 !== 1'b0) $display("[TB] FAIL basic_rsp_sel_dz: got sel=%b dz=%b expected 0000/0", rspSel1, rspDz1); else passCount++;
  endtask

  // Continues from the RESP state left by test_basic.
  task automatic test_backpressure();
    applyStimulus(1'b1, 4'hF, 4'hE, 4'hD, 1'b0, 4'h5, 4'hA);
    for (int k = 0; k < 5; k++) begin
      tick();
      checkCount++; if (rspValid1 !== 1'b1 || cmdReady1 !== 1'b0) $display("[TB] FAIL bp_flags_%0d: got valid=%b ready=%b expected 1/0", k, rspValid1, cmdReady1); else passCount++;
      checkCount++; if ({rspC1, rspOut1A, rspOut2A, rspSel1} !== 13'h1000) $display("[TB] FAIL bp_rsp_hold_%0d: got %h expected 1000", k, {rspC1, rspOut1A, rspOut2A, rspSel1}); else passCount++;
      checkCount++; if ({aluA1, aluB1, aluSel1} !== 12'b1011_0101_0000) $display("[TB] FAIL bp_alu_hold_%0d: got %h expected b50", k, {aluA1, aluB1, aluSel1}); else passCount++;
    end
    handshake();
    checkCount++; if (cmdReady1 !== 1'b1 || rspValid1 !== 1'b0) $display("[TB] FAIL bp_release_flags: got ready=%b valid=%b expected 1/0", cmdReady1, rspValid1); else passCount++;
    checkCount++; if (opCount1 !== 8'd1) $display("[TB] FAIL bp_op_count: got %0d expected 1", opCount1); else passCount++;
    checkCount++; if (aluA1 !== 4'b1011) $display("[TB] FAIL bp_no_accept_in_handshake: got %h expected b", aluA1); else passCount++;
    checkCount++; if (rspC1 !== 1'b1 || rspOut1A !== 4'h0) $display("[TB] FAIL bp_rsp_retained: got c=%b o1=%h expected 1/0", rspC1, rspOut1A); else passCount++;
    tick();
    cmdValid = 1'b0;
    checkCount++; if ({aluA1, aluB1, aluSel1} !== 12'hFED) $display("[TB] FAIL bp_next_accept: got %h expected fed", {aluA1, aluB1, aluSel1}); else passCount++;
    tick();
    handshake();
  endtask

  task automatic test_divzero();
    runOp(4'h9, 4'h0, 4'b0011, 1'b1, 4'hF, 4'h7);
    checkCount++; if (rspDz1 !== 1'b1) $display("[TB] FAIL dz_b0: got %b expected 1", rspDz1); else passCount++;
    checkCount++; if (rspOut1A !== 4'hF || rspOut2A !== 4'h7 || rspC1 !== 1'b1) $display("[TB] FAIL dz_unmodified: got o1=%h o2=%h c=%b expected f/7/1", rspOut1A, rspOut2A, rspC1); else passCount++;
    handshake();
    runOp(4'h9, 4'h1, 4'b0011, 1'b0, 4'h9, 4'h0);
    checkCount++; if (rspDz1 !== 1'b0) $display("[TB] FAIL dz_b1: got %b expected 0", rspDz1); else passCount++;
    handshake();
    runOp(4'h9, 4'h0, 4'b0010, 1'b0, 4'h1, 4'h0);
    checkCount++; if (rspDz1 !== 1'b0) $display("[TB] FAIL dz_other_sel: got %b expected 0", rspDz1); else passCount++;
    handshake();
  endtask

  task automatic test_latency();
    doReset();
    applyStimulus(1'b1, 4'h3, 4'h4, 4'h6, 1'b0, 4'h0, 4'h0);
    tick();
    cmdValid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      aluOut1 = 4'(k); aluOut2 = 4'(k + 8);
      tick();
      checkCount++; if (rspValid4 !== 1'b0) $display("[TB] FAIL lat_early_%0d: got %b expected 0", k, rspValid4); else passCount++;
    end
    aluC = 1'b1; aluOut1 = 4'h9; aluOut2 = 4'h6;
    tick();
    checkCount++; if (rspValid4 !== 1'b1) $display("[TB] FAIL lat_rise: got %b expected 1", rspValid4); else passCount++;
    checkCount++; if ({rspC4, rspOut1B, rspOut2B} !== 9'h196) $display("[TB] FAIL lat_capture: got %h expected 196", {rspC4, rspOut1B, rspOut2B}); else passCount++;
    checkCount++; if (rspSel4 !== 4'h6 || aluA4 !== 4'h3) $display("[TB] FAIL lat_sel_alu: got sel=%h a=%h expected 6/3", rspSel4, aluA4); else passCount++;
    handshake();
    checkCount++; if (opCount4 !== 8'd1 || cmdReady4 !== 1'b1) $display("[TB] FAIL lat_done: got cnt=%0d ready=%b expected 1/1", opCount4, cmdReady4); else passCount++;
  endtask

  task automatic test_reset_midop();
    doReset();
    applyStimulus(1'b1, 4'h7, 4'h2, 4'h5, 1'b1, 4'hE, 4'hD);
    tick();
    cmdValid = 1'b0;
    rst = 1'b1; tick(); rst = 1'b0;
    checkCount++; if (cmdReady1 !== 1'b1 || rspValid1 !== 1'b0) $display("[TB] FAIL rst_exec_flags: got ready=%b valid=%b expected 1/0", cmdReady1, rspValid1); else passCount++;
    checkCount++; if ({aluA1, aluB1, aluSel1, rspC1, rspOut1A, rspOut2A, rspSel1, rspDz1, opCount1} !== 35'h0) $display("[TB] FAIL rst_exec_zero: got %h expected 0", {aluA1, aluB1, aluSel1, rspC1, rspOut1A, rspOut2A, rspSel1, rspDz1, opCount1}); else passCount++;
    runOp(4'h7, 4'h2, 4'h5, 1'b1, 4'hE, 4'hD);
    checkCount++; if (rspValid1 !== 1'b1 || rspOut1A !== 4'hE) $display("[TB] FAIL rst_resp_setup: got valid=%b o1=%h expected 1/e", rspValid1, rspOut1A); else passCount++;
    rst = 1'b1; rspReady = 1'b1; cmdValid = 1'b1;
    tick();
    rst = 1'b0; rspReady = 1'b0; cmdValid = 1'b0;
    checkCount++; if (cmdReady1 !== 1'b1 || rspValid1 !== 1'b0) $display("[TB] FAIL rst_resp_flags: got ready=%b valid=%b expected 1/0", cmdReady1, rspValid1); else passCount++;
    checkCount++; if (opCount1 !== 8'd0) $display("[TB] FAIL rst_resp_op_count: got %0d expected 0", opCount1); else passCount++;
    checkCount++; if ({aluA1, aluB1, aluSel1, rspC1, rspOut1A, rspOut2A, rspSel1, rspDz1} !== 27'h0) $display("[TB] FAIL rst_resp_zero: got %h expected 0", {aluA1, aluB1, aluSel1, rspC1, rspOut1A, rspOut2A, rspSel1, rspDz1}); else passCount++;
  endtask

  task automatic test_wrap();
    logic [7:0] iv;
    doReset();
    for (int i = 0; i < 256; i++) begin
      iv = 8'(i);
      runOp(iv[7:4], ~iv[3:0], iv[3:0], iv[0], iv[7:4], iv[3:0]);
      checkCount++; if (rspSel1 !== iv[3:0]) $display("[TB] FAIL wrap_sel_%0d: got %h expected %h", i, rspSel1, iv[3:0]); else passCount++;
      handshake();
      if (i == 254) begin
        checkCount++; if (opCount1 !== 8'd255) $display("[TB] FAIL wrap_255: got %0d expected 255", opCount1); else passCount++;
      end
    end
    checkCount++; if (opCount1 !== 8'd0) $display("[TB] FAIL wrap_zero: got %0d expected 0", opCount1); else passCount++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_divzero();
    test_latency();
    test_reset_midop();
    test_wrap();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
